// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 register file plus exception/interrupt controller that sits
// beside the WB stage of the 5-stage pipeline.
//   Holds Status/Cause/EPC/BadVAddr/Count/Compare and resolves one WB-stage event
//   per cycle: interrupt > exc_req (MSB first) > ERET > MTC0.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   wb_valid/wb_pc/wb_delay_slot/wb_dm_addr   WB instruction context
//   exc_req[6:0]                {fetch_err,inst_rsv,overflow,syscall,brk,raddr_err,waddr_err}
//   wb_eret, wb_mtc0            WB instruction kind
//   cp0_addr, cp0_wdata         {rd,sel} for MFC0/MTC0 and MTC0 data
//   cp0_rdata                   MFC0 data (pre-update, combinational)
//   hw_int                      asynchronous level interrupt lines
//   exc_valid, exc_pc, cancel   IF redirect and pipeline flush
//   wb_commit_ok                0 blocks architectural write-back of the WB instruction
module cp0_exc_unit #(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wb_valid,
  input  logic [31:0]           wb_pc,
  input  logic                  wb_delay_slot,
  input  logic [31:0]           wb_dm_addr,
  input  logic [6:0]            exc_req,
  input  logic                  wb_eret,
  input  logic                  wb_mtc0,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           cp0_wdata,
  output logic [31:0]           cp0_rdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  exc_valid,
  output logic [31:0]           exc_pc,
  output logic                  cancel,
  output logic                  wb_commit_ok
);

  localparam int unsigned   PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  typedef enum logic [2:0] {EV_NONE, EV_INT, EV_EXC, EV_ERET, EV_MTC0} event_e;

  logic [NUM_HW_INT-1:0] hw_s1_q, hw_s2_q;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d, ti_q, ti_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic [PW-1:0] presc_q, presc_d;

  logic [7:0]  ip;
  logic        int_pend, presc_tick, wr_en;
  logic [4:0]  exc_code_sel;
  logic        sel_fetch, sel_daddr;
  event_e      ev;

  // Hardware IP bits follow the synchronised lines directly; only TI is sticky.
  always_comb begin
    ip                  = '0;
    ip[1:0]             = ip_sw_q;
    ip[2 +: NUM_HW_INT] = hw_s2_q;
    ip[7]               = ip[7] | ti_q;
  end

  assign int_pend = ie_q & ~exl_q & (|(im_q & ip));

  // Leftmost exc_req bit wins.
  always_comb begin
    exc_code_sel = 5'd0;
    sel_fetch    = 1'b0;
    sel_daddr    = 1'b0;
    if (exc_req[6]) begin
      exc_code_sel = 5'd4;
      sel_fetch    = 1'b1;
    end else if (exc_req[5]) begin
      exc_code_sel = 5'd10;
    end else if (exc_req[4]) begin
      exc_code_sel = 5'd12;
    end else if (exc_req[3]) begin
      exc_code_sel = 5'd8;
    end else if (exc_req[2]) begin
      exc_code_sel = 5'd9;
    end else if (exc_req[1]) begin
      exc_code_sel = 5'd4;
      sel_daddr    = 1'b1;
    end else if (exc_req[0]) begin
      exc_code_sel = 5'd5;
      sel_daddr    = 1'b1;
    end
  end

  always_comb begin
    ev = EV_NONE;
    if (wb_valid) begin
      if (int_pend)      ev = EV_INT;
      else if (|exc_req) ev = EV_EXC;
      else if (wb_eret)  ev = EV_ERET;
      else if (wb_mtc0)  ev = EV_MTC0;
    end
  end

  assign exc_valid    = (ev == EV_INT) || (ev == EV_EXC) || (ev == EV_ERET);
  assign exc_pc       = (ev == EV_ERET) ? epc_q : EXC_VECTOR;
  assign cancel       = exc_valid;
  assign wb_commit_ok = ~(wb_valid & (int_pend | (|exc_req)));
  assign wr_en        = (ev == EV_MTC0) && (cp0_addr[2:0] == 3'd0);
  assign presc_tick   = (presc_q == PRESC_LAST);

  always_comb begin
    cp0_rdata = '0;
    if (cp0_addr[2:0] == 3'd0) begin
      case (cp0_addr[7:3])
        REG_BADVADDR: cp0_rdata = badvaddr_q;
        REG_COUNT:    cp0_rdata = count_q;
        REG_COMPARE:  cp0_rdata = compare_q;
        REG_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
        REG_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
        REG_EPC:      cp0_rdata = epc_q;
        default:      cp0_rdata = '0;
      endcase
    end
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    count_d    = count_q;
    presc_d    = presc_tick ? '0 : presc_q + PW'(1);

    // Count write beats the prescaled increment and cannot raise TI by itself.
    if (wr_en && cp0_addr[7:3] == REG_COUNT) begin
      count_d = cp0_wdata;
      presc_d = '0;
    end else if (presc_tick) begin
      count_d = count_q + 32'd1;
      if (count_q + 32'd1 == compare_q) ti_d = 1'b1;
    end

    case (ev)
      EV_INT, EV_EXC: begin
        exl_d      = 1'b1;
        exc_code_d = (ev == EV_INT) ? 5'd0 : exc_code_sel;
        // Nested exception keeps the original return point.
        if (!exl_q) begin
          bd_d  = wb_delay_slot;
          epc_d = wb_delay_slot ? wb_pc - 32'd4 : wb_pc;
        end
        if (ev == EV_EXC && sel_fetch) badvaddr_d = wb_pc;
        if (ev == EV_EXC && sel_daddr) badvaddr_d = wb_dm_addr;
      end
      EV_ERET: exl_d = 1'b0;
      default: ;
    endcase

    if (wr_en) begin
      case (cp0_addr[7:3])
        REG_COMPARE: begin
          compare_d = cp0_wdata;
          ti_d      = 1'b0;
        end
        REG_STATUS: begin
          im_d  = cp0_wdata[15:8];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        REG_CAUSE: ip_sw_d = cp0_wdata[9:8];
        REG_EPC:   epc_d   = cp0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hw_s1_q    <= '0;
      hw_s2_q    <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      presc_q    <= '0;
    end else begin
      hw_s1_q    <= hw_int;
      hw_s2_q    <= hw_s1_q;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      presc_q    <= presc_d;
    end
  end

endmodule
